// File: rtl/piso_pkg.sv
// Shared types and helpers for the parallel-in, serial-out transmitter.
package piso_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_e;

   // Counter must be able to hold SIZE itself after the final shift.
   function automatic int cnt_width(input int size);
      return $clog2(size + 1);
   endfunction

endpackage

// File: rtl/piso_shift_reg_shift_cell.sv
// One bit of the shift register: load has priority over shift, otherwise hold.
module shift_cell (
   input  logic clk,
   input  logic rst,
   input  logic load,
   input  logic shift,
   input  logic pin_bit,
   input  logic nbr_bit,
   output logic q
);

   logic bit_d;
   logic bit_q;

   always_comb begin
      // NOTE: default first so every path assigns bit_d and no latch is inferred.
      bit_d = bit_q;
      if (load) begin
         bit_d = pin_bit;
      end else if (shift) begin
         bit_d = nbr_bit;
      end
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bit_q <= 1'b0;
      end else begin
         bit_q <= bit_d;
      end
   end

   assign q = bit_q;

endmodule

// File: rtl/piso_shift_reg.sv
// Parallel-in, serial-out transmitter with valid/ready load, shift enable and done pulse.
module piso_shift_reg
   import piso_pkg::*;
#(
   parameter int SIZE      = 10,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            load_valid,
   output logic            load_ready,
   input  logic [SIZE-1:0] pin,
   input  logic            shift_en,
   output logic            sout,
   output logic            sout_valid,
   output logic            busy,
   output logic            done
);

   localparam int               CNT_W    = cnt_width(SIZE);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SIZE - 1);
   localparam int               OUT_IDX  = MSB_FIRST ? SIZE - 1 : 0;

   state_e           state_d, state_q;
   logic [CNT_W-1:0] cnt_d, cnt_q;
   logic [SIZE-1:0]  shreg;
   logic [SIZE-1:0]  nbr;
   logic             do_load;
   logic             do_shift;

   assign do_load  = (state_q == ST_IDLE) && load_valid;
   assign do_shift = (state_q == ST_SHIFT) && shift_en;

   // Neighbour wiring decides the shift direction; the far end fills with 0.
   for (genvar i = 0; i < SIZE; i++) begin : g_cell
      if (MSB_FIRST) begin : g_msb
         if (i == 0) begin : g_end
            assign nbr[i] = 1'b0;
         end else begin : g_mid
            assign nbr[i] = shreg[i-1];
         end
      end else begin : g_lsb
         if (i == SIZE - 1) begin : g_end
            assign nbr[i] = 1'b0;
         end else begin : g_mid
            assign nbr[i] = shreg[i+1];
         end
      end

      shift_cell u_cell (
         .clk     (clk),
         .rst     (rst),
         .load    (do_load),
         .shift   (do_shift),
         .pin_bit (pin[i]),
         .nbr_bit (nbr[i]),
         .q       (shreg[i])
      );
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         ST_IDLE: begin
            if (load_valid) begin
               cnt_d   = '0;
               state_d = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            if (shift_en) begin
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == CNT_LAST) begin
                  state_d = ST_DONE;
               end
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Outputs decode registered state only; sout is gated to 0 outside SHIFT.
   assign load_ready = (state_q == ST_IDLE);
   assign sout_valid = (state_q == ST_SHIFT);
   assign busy       = (state_q == ST_SHIFT);
   assign done       = (state_q == ST_DONE);
   assign sout       = sout_valid & shreg[OUT_IDX];

endmodule

// File: tb/tb_piso_shift_reg.sv
// Self-checking bench: three instances (MSB-first, LSB-first, SIZE=1) against a bit-order model.
module tb_piso_shift_reg;

   logic       clk;
   logic       rst;
   logic [2:0] lv;
   logic [2:0] se;
   logic [9:0] pin_a;
   logic [9:0] pin_b;
   logic [0:0] pin_c;
   logic [2:0] lr, so, sv, bz, dn;

   int checks;
   int errors;

   piso_shift_reg #(.SIZE(10), .MSB_FIRST(1'b1)) dut_msb (
      .clk(clk), .rst(rst), .load_valid(lv[0]), .load_ready(lr[0]), .pin(pin_a),
      .shift_en(se[0]), .sout(so[0]), .sout_valid(sv[0]), .busy(bz[0]), .done(dn[0])
   );

   piso_shift_reg #(.SIZE(10), .MSB_FIRST(1'b0)) dut_lsb (
      .clk(clk), .rst(rst), .load_valid(lv[1]), .load_ready(lr[1]), .pin(pin_b),
      .shift_en(se[1]), .sout(so[1]), .sout_valid(sv[1]), .busy(bz[1]), .done(dn[1])
   );

   piso_shift_reg #(.SIZE(1), .MSB_FIRST(1'b1)) dut_one (
      .clk(clk), .rst(rst), .load_valid(lv[2]), .load_ready(lr[2]), .pin(pin_c),
      .shift_en(se[2]), .sout(so[2]), .sout_valid(sv[2]), .busy(bz[2]), .done(dn[2])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%b expected=%b at %0t", tag, obs, exp, $time);
      end
   endtask

   // Bit i of the serial stream, straight from the word and the transmit order.
   function automatic logic exp_bit(input logic [9:0] w, input int size, input bit msb, input int i);
      return msb ? w[size-1-i] : w[i];
   endfunction

   task automatic set_pin(input int d, input logic [9:0] w);
      if (d == 0) pin_a = w;
      else if (d == 1) pin_b = w;
      else pin_c = w[0];
   endtask

   task automatic check_idle(input int d, input string tag);
      check({tag, "_ready"}, lr[d], 1'b1);
      check({tag, "_sout"},  so[d], 1'b0);
      check({tag, "_valid"}, sv[d], 1'b0);
      check({tag, "_busy"},  bz[d], 1'b0);
      check({tag, "_done"},  dn[d], 1'b0);
   endtask

   // Called at a falling edge with the DUT in IDLE; returns at the falling
   // edge of the IDLE cycle that follows DONE.
   task automatic send_word(input int d, input logic [9:0] w, input int stall_at,
                            input int stall_len, input bit intrude);
      int size;
      bit msb;
      size = (d == 2) ? 1 : 10;
      msb  = (d != 1);
      check("idle_ready", lr[d], 1'b1);
      lv[d] = 1'b1;
      set_pin(d, w);
      @(negedge clk);
      lv[d] = 1'b0;
      for (int i = 0; i < size; i++) begin
         int holds;
         holds = (i == stall_at) ? stall_len : 0;
         for (int h = 0; h <= holds; h++) begin
            se[d] = (h < holds) ? 1'b0 : 1'b1;
            if (intrude && i == 2 && h == 0) begin
               lv[d] = 1'b1;
               set_pin(d, 10'h3FF);
            end
            check("sout_bit",   so[d], exp_bit(w, size, msb, i));
            check("sout_valid", sv[d], 1'b1);
            check("busy",       bz[d], 1'b1);
            check("ready_low",  lr[d], 1'b0);
            check("no_done",    dn[d], 1'b0);
            @(negedge clk);
         end
      end
      se[d] = 1'b1;
      check("done_pulse",   dn[d], 1'b1);
      check("done_busy",    bz[d], 1'b0);
      check("done_valid",   sv[d], 1'b0);
      check("done_sout",    so[d], 1'b0);
      check("done_ready",   lr[d], 1'b0);
      @(negedge clk);
      check("after_ready",  lr[d], 1'b1);
      check("after_done",   dn[d], 1'b0);
      check("after_valid",  sv[d], 1'b0);
   endtask

   initial begin
      logic [9:0] w;
      checks = 0;
      errors = 0;
      rst    = 1'b0;
      lv     = '0;
      se     = 3'b111;
      pin_a  = '0;
      pin_b  = '0;
      pin_c  = '0;
      repeat (2) @(negedge clk);
      for (int d = 0; d < 3; d++) check_idle(d, "reset");
      rst = 1'b1;
      @(negedge clk);

      // Directed words: default order, LSB-first, stall on bit 4.
      send_word(0, 10'h2B5, -1, 0, 1'b0);
      send_word(1, 10'h2B5, -1, 0, 1'b0);
      send_word(0, 10'h2B5, 4, 3, 1'b0);

      // Load attempt while busy, then held valid is taken after IDLE.
      send_word(0, 10'h155, -1, 0, 1'b1);
      send_word(0, 10'h3FF, -1, 0, 1'b0);

      // Single-bit instance.
      send_word(2, 10'h001, -1, 0, 1'b0);
      send_word(2, 10'h000, -1, 0, 1'b0);

      // Random words and stalls on both wide instances.
      repeat (6) begin
         for (int d = 0; d < 2; d++) begin
            w = 10'($urandom);
            send_word(d, w, int'($urandom_range(0, 12)), int'($urandom_range(0, 3)), 1'b0);
         end
      end

      // Reset between edges while bit 6 is on the line.
      w = 10'h2B5;
      lv[0] = 1'b1;
      pin_a = w;
      @(negedge clk);
      lv[0] = 1'b0;
      repeat (6) @(negedge clk);
      check("pre_reset_bit6", so[0], exp_bit(w, 10, 1'b1, 6));
      #2 rst = 1'b0;
      #1 check_idle(0, "mid_reset");
      repeat (3) begin
         @(negedge clk);
         check_idle(0, "held_reset");
      end
      rst = 1'b1;
      @(negedge clk);
      check_idle(0, "post_reset");
      w = 10'($urandom);
      send_word(0, w, -1, 0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
